polyeval_seq: RTL

Sequencer that evaluates a polynomial modulo MOD_NUM by driving the polyeval ALU with Horner's method: acc = (coef[i] + acc*x) % MOD_NUM, for i = deg down to 0.
It accepts a start command carrying degree and x, reads coefficients from an external synchronous coefficient RAM, and issues one ALU operation per term.
It checks the ALU's returned order count, and returns the final result with a done pulse.
It sits between the host/command logic and one polyeval_alu instance.

---
 rtl/polyeval_pkg.sv | 20 ++
 rtl/polyeval_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/polyeval_pkg.sv
// Shared definitions for the polynomial-evaluation sequencer.
//   - default widths for data, evaluation point and term counter
//   - default ALU result timeout
//   - sequencer state encoding
package polyeval_pkg;

    localparam int WID_D_DEF   = 32;
    localparam int WID_F_DEF   = 32;
    localparam int CNT_W_DEF   = 5;
    localparam int TMO_CYC_DEF = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/polyeval_seq.sv
// Horner-method polynomial sequencer driving one polyeval ALU.
// Each term: read coef[i] from the synchronous RAM, issue
// acc = (coef[i] + acc*x) mod MOD_NUM to the ALU, wait for the result.
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   i_start, i_abort            command strobe / synchronous abort
//   i_deg, i_x_in               degree and evaluation point (sampled with start)
//   o_busy, o_done, o_err       status; done/err are one-cycle pulses
//   o_result                    final accumulator, held between runs
//   o_coef_rd_en, o_coef_addr   coefficient RAM read port
//   i_coef_rd_data              RAM data, valid one cycle after the read strobe
//   o_alu_*                     ALU operation request
//   i_alu_res_vld, i_alu_res,
//   i_alu_order_cnt_o           ALU response
//
// state | meaning
// IDLE  | waiting for start
// FETCH | coefficient RAM read of coef[i]
// ISSUE | RAM data presented to the ALU with acc, x and term index
// WAIT  | waiting for ALU result, timeout counter running
// DONE  | result valid, done (and err) pulse
module polyeval_seq
    import polyeval_pkg::*;
#(
    parameter int WID_D   = WID_D_DEF,
    parameter int WID_F   = WID_F_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_deg,
    input  logic [WID_F-1:0] i_x_in,
    output logic             o_busy,
    output logic             o_done,
    output logic [WID_D-1:0] o_result,
    output logic             o_err,
    output logic             o_coef_rd_en,
    output logic [CNT_W-1:0] o_coef_addr,
    input  logic [WID_D-1:0] i_coef_rd_data,
    output logic             o_alu_vld,
    output logic [WID_D-1:0] o_alu_a_left,
    output logic [WID_D-1:0] o_alu_a_right,
    output logic [WID_F-1:0] o_alu_factor,
    output logic [CNT_W-1:0] o_alu_order_cnt,
    input  logic             i_alu_res_vld,
    input  logic [WID_D-1:0] i_alu_res,
    input  logic [CNT_W-1:0] i_alu_order_cnt_o
);

    localparam int TMO_W = $clog2(TMO_CYC + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_i;
    logic [CNT_W-1:0] r_deg;
    logic [WID_F-1:0] r_x;
    logic [WID_D-1:0] r_acc;
    logic [WID_D-1:0] r_result;
    logic             r_err;
    logic [TMO_W-1:0] r_tmo;

    logic [CNT_W-1:0] w_order;
    logic [CNT_W-1:0] w_order_exp;
    logic             w_err_nxt;
    logic             w_accept;

    // deg and i are stable from ISSUE through WAIT, so the issued
    // term index can be recomputed when the response is checked.
    assign w_order     = r_deg - r_i;
    assign w_order_exp = w_order + CNT_W'(1);
    assign w_accept    = i_start && !i_abort;

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE:  if (w_accept) w_state_nxt = FETCH;
            FETCH: w_state_nxt = ISSUE;
            ISSUE: w_state_nxt = WAIT;
            WAIT: begin
                if (i_alu_res_vld) begin
                    if (i_alu_order_cnt_o != w_order_exp) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = DONE;
                    end else if (r_i == '0) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = FETCH;
                    end
                end else if (r_tmo == '0) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (i_abort && r_state != IDLE) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_i      <= '0;
            r_deg    <= '0;
            r_x      <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_tmo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_deg <= i_deg;
                        r_x   <= i_x_in;
                        r_i   <= i_deg;
                        r_acc <= '0;
                        r_err <= 1'b0;
                    end
                end
                ISSUE: r_tmo <= TMO_W'(TMO_CYC - 1);
                WAIT: begin
                    if (!i_abort) begin
                        if (i_alu_res_vld) begin
                            r_acc <= i_alu_res;
                        end else if (r_tmo != '0) begin
                            r_tmo <= r_tmo - TMO_W'(1);
                        end
                        if (w_state_nxt == FETCH) begin
                            r_i <= r_i - CNT_W'(1);
                        end
                        // Result is captured on entry to DONE so it is valid
                        // alongside the done pulse and survives later aborts.
                        if (w_state_nxt == DONE) begin
                            r_err    <= w_err_nxt;
                            r_result <= i_alu_res_vld ? i_alu_res : r_acc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Every request output is gated by state so that reset (IDLE) drives 0.
    always_comb begin
        o_busy          = (r_state != IDLE);
        o_done          = (r_state == DONE);
        o_err           = (r_state == DONE) && r_err;
        o_result        = r_result;
        o_coef_rd_en    = (r_state == FETCH);
        o_coef_addr     = (r_state == FETCH) ? r_i : '0;
        o_alu_vld       = (r_state == ISSUE);
        o_alu_a_left    = (r_state == ISSUE) ? i_coef_rd_data : '0;
        o_alu_a_right   = (r_state == ISSUE) ? r_acc : '0;
        o_alu_factor    = (r_state == ISSUE) ? r_x : '0;
        o_alu_order_cnt = (r_state == ISSUE) ? w_order : '0;
    end

endmodule
